// File: rtl/booth_accum.sv
// Saturating dot-product accumulator for the radix-4 Booth multiplier output stream.
// Sums a programmed number of signed products and hands the result over a valid/ready port.
module booth_accum #(
  parameter int PROD_W = 9,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     clr,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic                     out_sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One guard bit above the wider operand, so the raw sum can never wrap.
  localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  localparam logic signed [SUM_W-1:0] ACC_MAX =
    {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN =
    {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic                      sat;
  logic        [LEN_W-1:0]   remaining;

  logic signed [SUM_W-1:0]   sum_wide;
  logic signed [SUM_W-1:0]   sum_clamped;
  logic                      clamp;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // any path that skips the assignment infers a latch.
  always_comb begin
    sum_wide    = $signed({{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc})
                + $signed({{(SUM_W-PROD_W){in_product[PROD_W-1]}}, in_product});
    sum_clamped = sum_wide;
    clamp       = 1'b0;
    if (sum_wide > ACC_MAX) begin
      sum_clamped = ACC_MAX;
      clamp       = 1'b1;
    end else if (sum_wide < ACC_MIN) begin
      sum_clamped = ACC_MIN;
      clamp       = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      acc       <= '0;
      sat       <= 1'b0;
      remaining <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clr) begin
      // Abort wins over start and both handshakes; a result in flight is dropped.
      state     <= IDLE;
      acc       <= '0;
      sat       <= 1'b0;
      remaining <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            remaining <= cfg_len;
            acc       <= '0;
            sat       <= 1'b0;
            busy      <= 1'b1;
            if (cfg_len == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state     <= ACCUM;
              in_ready  <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (in_valid && in_ready) begin
            acc       <= sum_clamped[ACC_W-1:0];
            sat       <= sat | clamp;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_acc = acc;
  assign out_sat = sat;

endmodule

// File: tb/tb_booth_accum.sv
// Directed self-checking bench for booth_accum with an 8-bit accumulator so the
// saturation rails are reachable; expected sums are queued at start, checked at out_valid.
module tb_booth_accum;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 8;
  localparam int LEN_W  = 4;

  typedef struct {
    int acc;
    int sat;
  } result_t;

  logic                     clk;
  logic                     resetn;
  logic                     start;
  logic [LEN_W-1:0]         cfg_len;
  logic                     clr;
  logic                     busy;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_product;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic                     out_sat;

  result_t sb[$];
  int      tests_run = 0;
  int      tests_failed = 0;

  booth_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .cfg_len    (cfg_len),
    .clr        (clr),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_sat    (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input int acc, input int sat);
    result_t r;
    r.acc = acc;
    r.sat = sat;
    sb.push_back(r);
  endtask

  task automatic start_sum(input int len);
    start   = 1'b1;
    cfg_len = LEN_W'(len);
    tick();
    start   = 1'b0;
  endtask

  task automatic send(input string tag, input int p, input int gap);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, int'(in_ready), 1);
    in_valid   = 1'b1;
    in_product = PROD_W'(p);
    tick();
    in_valid   = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_result(input string tag);
    result_t exp;
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_out_valid"}, int'(out_valid), 1);
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, "_acc"}, int'(out_acc), exp.acc);
      check({tag, "_sat"}, int'(out_sat), exp.sat);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(out_valid), 0);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int seen_valid;

    resetn     = 1'b0;
    start      = 1'b0;
    cfg_len    = '0;
    clr        = 1'b0;
    in_valid   = 1'b0;
    in_product = '0;
    out_ready  = 1'b0;
    #12;
    check("rst_busy",      int'(busy),      0);
    check("rst_in_ready",  int'(in_ready),  0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_acc",   int'(out_acc),   0);
    check("rst_out_sat",   int'(out_sat),   0);
    tick();
    resetn = 1'b1;
    tick();

    // Basic sum, with first-cycle and last-accept timing.
    expect_result(70, 0);
    start_sum(3);
    check("basic_in_ready_k1", int'(in_ready), 1);
    check("basic_busy", int'(busy), 1);
    send("basic_p0", 12, 0);
    send("basic_p1", -6, 0);
    send("basic_p2", 64, 0);
    check("basic_valid_n", int'(out_valid), 1);
    check("basic_in_ready_done", int'(in_ready), 0);
    wait_result("basic");

    // Positive rail.
    expect_result(127, 1);
    start_sum(2);
    send("satp_p0", 64, 0);
    send("satp_p1", 64, 0);
    wait_result("satp");

    // Negative rail, held by a further negative add.
    expect_result(-128, 1);
    start_sum(3);
    send("satn_p0", -56, 0);
    send("satn_p1", -56, 0);
    send("satn_p2", -56, 0);
    wait_result("satn");

    // Clamp per add: the opposite-sign add pulls the value off the rail.
    expect_result(27, 1);
    start_sum(3);
    send("clampadd_p0", 100, 0);
    send("clampadd_p1", 100, 0);
    send("clampadd_p2", -100, 0);
    wait_result("clampadd");

    // Input gaps of two cycles.
    expect_result(25, 0);
    start_sum(4);
    send("gap_p0", 10, 2);
    send("gap_p1", -20, 2);
    send("gap_p2", 30, 2);
    check("gap_busy_mid", int'(busy), 1);
    send("gap_p3", 5, 2);
    wait_result("gap");

    // Output back-pressure: held result, ignored start, unconsumed product.
    expect_result(33, 0);
    start_sum(1);
    send("bp_p0", 33, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid",    int'(out_valid), 1);
      check("bp_hold_acc",      int'(out_acc),   33);
      check("bp_hold_in_ready", int'(in_ready),  0);
      check("bp_hold_busy",     int'(busy),      1);
      start      = (i == 2);
      cfg_len    = '0;
      in_valid   = 1'b1;
      in_product = PROD_W'(99);
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    wait_result("bp");
    tick();
    check("bp_start_ignored", int'(busy), 0);

    // Empty sum.
    expect_result(0, 0);
    start_sum(0);
    check("len0_valid_k", int'(out_valid), 1);
    check("len0_in_ready", int'(in_ready), 0);
    wait_result("len0");

    // clr after two of five products; no result may ever appear.
    start_sum(5);
    send("clr_p0", 20, 0);
    send("clr_p1", 30, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy",     int'(busy),     0);
    check("clr_in_ready", int'(in_ready), 0);
    check("clr_acc",      int'(out_acc),  0);
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen_valid = 1;
      in_valid   = 1'b1;
      in_product = PROD_W'(1);
      tick();
    end
    in_valid = 1'b0;
    check("clr_no_valid", seen_valid, 0);

    // clr beats an output handshake in the same cycle.
    start_sum(1);
    send("clrhs_p0", 5, 0);
    check("clrhs_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    clr       = 1'b1;
    tick();
    out_ready = 1'b0;
    clr       = 1'b0;
    check("clrhs_valid_drop", int'(out_valid), 0);
    check("clrhs_acc", int'(out_acc), 0);

    // Asynchronous reset mid-sum, away from any clock edge.
    start_sum(3);
    send("rstmid_p0", 40, 0);
    check("rstmid_acc_pre", int'(out_acc), 40);
    #2;
    resetn = 1'b0;
    #1;
    check("rstmid_busy",     int'(busy),     0);
    check("rstmid_in_ready", int'(in_ready), 0);
    check("rstmid_acc",      int'(out_acc),  0);
    check("rstmid_valid",    int'(out_valid), 0);
    tick();
    resetn = 1'b1;
    tick();
    check("rstmid_idle", int'(busy), 0);

    // Fresh sum after reset.
    expect_result(-7, 0);
    start_sum(1);
    send("post_p0", -7, 0);
    wait_result("post");

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
